// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   op_e    - operation codes carried on the 4-bit op input (13..15 are illegal)
//   state_e - control FSM encoding (IDLE / RUN / DONE)
//   is_iter - true for the ops handled by the iterative multiply/divide unit
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_SHR = 4'd4,
      OP_SHL = 4'd5,
      OP_ROR = 4'd6,
      OP_ROL = 4'd7,
      OP_AND = 4'd8,
      OP_OR  = 4'd9,
      OP_NEG = 4'd10,
      OP_NOT = 4'd11,
      OP_INC = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_iter(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned shift-add multiplier / restoring divider.
//   clk, reset  - clock and synchronous active-low reset
//   load        - capture a_in/b_in/is_div and clear the iteration counter
//   step        - perform one iteration (one bit of the operation)
//   is_div      - 1 selects division, 0 multiplication (captured on load)
//   a_in, b_in  - operands
//   last        - current step is the final (WIDTH-th) iteration
//   hi_nxt, lo_nxt - register contents after the current step; after the last
//                    step these are {product} or {remainder, quotient}
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             last,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH:0]   sum, shifted;
   logic             fits;

   // Multiply: lo holds the remaining multiplier bits, hi the partial product;
   // each step adds b when lo[0] is set and shifts {carry,hi,lo} right by one.
   // Divide: {hi,lo} shifts left into the remainder; the quotient bit enters lo[0].
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted = {hi_q, lo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, b_q});
      if (div_q) begin
         hi_nxt = fits ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
         lo_nxt = {lo_q[WIDTH-2:0], fits};
      end else begin
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
      end
      last = (cnt_q == CW'(WIDTH - 1));
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      div_d = div_q;
      if (load) begin
         hi_d  = '0;
         lo_d  = a_in;
         b_d   = b_in;
         cnt_d = '0;
         div_d = is_div;
      end else if (step) begin
         hi_d  = hi_nxt;
         lo_d  = lo_nxt;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops and iterative MUL/DIV.
//   clk, reset            - clock and synchronous active-low reset
//   start, op, a, b       - request strobe, op code and operands
//   busy                  - high while an iterative op runs
//   done                  - one-cycle pulse, results/flags valid
//   result_hi, result_lo  - result words (held until the next done)
//   div_by_zero, illegal_op - status flags valid with done
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero,
   output logic             illegal_op
);

   localparam int unsigned SW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic               dbz_q, dbz_d, ill_q, ill_d;
   logic               accept, iter_go;
   logic [WIDTH-1:0]   sc_hi, sc_lo;
   logic               sc_dbz, sc_ill;
   logic [2*WIDTH-1:0] rot_l, rot_r;
   logic               md_last;
   logic [WIDTH-1:0]   md_hi, md_lo;

   // DIV by zero resolves in one cycle; every other MUL/DIV iterates.
   assign accept  = start && (state_q != S_RUN);
   assign iter_go = accept && is_iter(op) && !((op == OP_DIV) && (b == '0));

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .load   (iter_go),
      .step   (state_q == S_RUN),
      .is_div (op == OP_DIV),
      .a_in   (a),
      .b_in   (b),
      .last   (md_last),
      .hi_nxt (md_hi),
      .lo_nxt (md_lo)
   );

   // Rotations use a doubled operand so a zero amount naturally returns a.
   always_comb begin
      rot_l  = {a, a} << b[SW-1:0];
      rot_r  = {a, a} >> b[SW-1:0];
      sc_hi  = '0;
      sc_lo  = '0;
      sc_dbz = 1'b0;
      sc_ill = 1'b0;
      case (op)
         OP_ADD: sc_lo = a + b;
         OP_SUB: sc_lo = a - b;
         OP_DIV: begin
            sc_lo  = '1;
            sc_hi  = a;
            sc_dbz = 1'b1;
         end
         OP_SHR: sc_lo = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b);
         OP_SHL: sc_lo = (b >= WIDTH'(WIDTH)) ? '0 : (a << b);
         OP_ROR: sc_lo = rot_r[WIDTH-1:0];
         OP_ROL: sc_lo = rot_l[2*WIDTH-1:WIDTH];
         OP_AND: sc_lo = a & b;
         OP_OR:  sc_lo = a | b;
         OP_NEG: sc_lo = '0 - a;
         OP_NOT: sc_lo = ~a;
         OP_INC: sc_lo = a + 1'b1;
         OP_MUL: sc_lo = '0;
         default: sc_ill = 1'b1;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (iter_go)     state_d = S_RUN;
            else if (accept) state_d = S_DONE;
            else             state_d = S_IDLE;
         end
         S_RUN:   if (md_last) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Result registers load only on the edge that enters DONE.
   always_comb begin
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      dbz_d    = dbz_q;
      ill_d    = ill_q;
      if ((state_q == S_RUN) && md_last) begin
         res_hi_d = md_hi;
         res_lo_d = md_lo;
         dbz_d    = 1'b0;
         ill_d    = 1'b0;
      end else if (accept && !iter_go) begin
         res_hi_d = sc_hi;
         res_lo_d = sc_lo;
         dbz_d    = sc_dbz;
         ill_d    = sc_ill;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         res_hi_q <= '0;
         res_lo_q <= '0;
         dbz_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         dbz_q    <= dbz_d;
         ill_q    <= ill_d;
      end
   end

   assign result_hi   = res_hi_q;
   assign result_lo   = res_lo_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu (WIDTH=32).
module tb_seq_alu;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, div_by_zero, illegal_op;
   logic [W-1:0]  result_hi, result_lo;

   int checks = 0;
   int failures = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural reference: plain arithmetic on the operation's definition.
   function automatic void ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output logic il, output int lat);
      logic [63:0] p;
      int unsigned r;
      hi = '0; lo = '0; dz = 1'b0; il = 1'b0; lat = 1;
      r = y % 32;
      case (o)
         4'd0:  lo = x + y;
         4'd1:  lo = x - y;
         4'd2:  begin p = 64'(x) * 64'(y); hi = p[63:32]; lo = p[31:0]; lat = 33; end
         4'd3:  if (y == 0) begin lo = 32'hFFFF_FFFF; hi = x; dz = 1'b1; end
                else begin lo = x / y; hi = x % y; lat = 33; end
         4'd4:  lo = (y >= 32) ? 32'd0 : (x >> y);
         4'd5:  lo = (y >= 32) ? 32'd0 : (x << y);
         4'd6:  lo = (r == 0) ? x : ((x >> r) | (x << (32 - r)));
         4'd7:  lo = (r == 0) ? x : ((x << r) | (x >> (32 - r)));
         4'd8:  lo = x & y;
         4'd9:  lo = x | y;
         4'd10: lo = 32'd0 - x;
         4'd11: lo = ~x;
         4'd12: lo = x + 1;
         default: il = 1'b1;
      endcase
   endfunction

   // Issue one op, wait (bounded) for done, compare against the model.
   // With noise set, junk starts are thrown in while busy; they must be ignored.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit noise, input string tag);
      logic [31:0] eh, el;
      logic        ed, ei;
      int          elat, lat, bz;
      ref_op(o, x, y, eh, el, ed, ei, elat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      bz = 0;
      while (!done && lat < 200) begin
         if (busy) bz++;
         if (noise && busy && $urandom_range(0, 3) == 0) begin
            start = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_busycyc"}, bz, elat - 1);
      chk({tag, "_hi"}, result_hi, eh);
      chk({tag, "_lo"}, result_lo, el);
      chk({tag, "_dbz"}, div_by_zero, ed);
      chk({tag, "_ill"}, illegal_op, ei);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done, 1'b0);
      chk({tag, "_hold"}, {result_hi, result_lo}, {eh, el});
   endtask

   initial begin
      int dn;
      logic [3:0]  ro;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_res", {result_hi, result_lo}, 64'd0);
      chk("rst_flags", {div_by_zero, illegal_op}, 2'b00);
      reset = 1'b1;

      run_op(4'd0,  32'hFFFF_FFFF, 32'd2,          1'b0, "add_wrap");
      run_op(4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, "mul_max");
      run_op(4'd3,  32'd100,       32'd7,          1'b0, "div_100_7");
      run_op(4'd3,  32'd5,         32'd0,          1'b0, "div_zero");
      run_op(4'd7,  32'h8000_0001, 32'd33,         1'b0, "rol_33");
      run_op(4'd4,  32'hFFFF_FFFF, 32'd32,         1'b0, "shr_32");
      run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0,  1'b0, "illegal");
      run_op(4'd6,  32'hDEAD_BEEF, 32'd64,         1'b0, "ror_0");
      run_op(4'd5,  32'h0000_0003, 32'd31,         1'b0, "shl_31");
      run_op(4'd3,  32'd7,         32'd100,        1'b0, "div_small");
      run_op(4'd2,  32'hABCD_1234, 32'd0,          1'b0, "mul_zero");

      // Back-to-back: start held into DONE with fresh operands.
      @(negedge clk);
      start = 1'b1; op = 4'd0; a = 32'd10; b = 32'd20;
      @(posedge clk); #1;
      chk("b2b_done1", done, 1'b1);
      chk("b2b_lo1", result_lo, 32'd30);
      a = 32'd7; b = 32'd8;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_done2", done, 1'b1);
      chk("b2b_lo2", result_lo, 32'd15);
      @(posedge clk); #1;
      chk("b2b_end", done, 1'b0);

      // Reset during a MUL aborts it with no done pulse.
      @(negedge clk);
      start = 1'b1; op = 4'd2; a = $urandom; b = $urandom | 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 5) begin start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; end
         if (i == 6) start = 1'b0;
         if (i == 10) reset = 1'b0;
         if (done) dn++;
         @(posedge clk); #1;
      end
      chk("abort_busy", busy, 1'b0);
      chk("abort_done_now", done, 1'b0);
      chk("abort_res", {result_hi, result_lo}, 64'd0);
      chk("abort_flags", {div_by_zero, illegal_op}, 2'b00);
      reset = 1'b1;
      repeat (40) begin
         if (done) dn++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", dn, 0);
      run_op(4'd0, 32'd3, 32'd4, 1'b0, "add_after_abort");

      // Randomized ops with junk starts while busy.
      for (int n = 0; n < 60; n++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(0, 40);
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 1'b1, $sformatf("rnd%0d_op%0d", n, ro));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  input  1  request strobe; SHALL be accepted only when busy is low.
REQ-005 op  input  4  operation code: ADD=0 SUB=1 MUL=2 DIV=3 SHR=4 SHL=5 ROR=6 ROL=7 AND=8 OR=9 NEG=10 NOT=11 INC=12.
REQ-006 a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-007 b  input  WIDTH  operand B or shift count, sampled only when start is accepted.
REQ-008 busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result outputs are valid in that cycle.
REQ-010 result_hi  output  WIDTH  upper result word (product high, remainder).
REQ-011 result_lo  output  WIDTH  lower result word (sum, product low, quotient, etc.).
REQ-012 div_by_zero  output  1  valid with done; high when a DIV had b==0.
REQ-013 illegal_op  output  1  valid with done; high when op is 13..15.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; busy SHALL equal (state==RUN).
REQ-015 IDLE or DONE with start: single-cycle ops, illegal ops and DIV with b==0 -> DONE; MUL or DIV with b!=0 -> RUN.
REQ-016 DONE without start -> IDLE; done SHALL be high exactly in DONE.
REQ-017 RUN SHALL last exactly WIDTH cycles, one iteration per cycle, then -> DONE; MUL/DIV latency from accepted start to done = WIDTH+1 cycles; all other ops = 1 cycle.
REQ-018 start while busy SHALL be ignored, with no effect on state or operands.
REQ-019 ADD, SUB, INC, NEG SHALL use modulo 2^WIDTH arithmetic, discarding carry; result_hi=0.
REQ-020 AND, OR, NOT SHALL be bitwise; result_hi=0.
REQ-021 MUL SHALL be unsigned shift-add over 2*WIDTH bits; {result_hi,result_lo} = a*b.
REQ-022 DIV SHALL be unsigned restoring division; result_lo=quotient, result_hi=remainder.
REQ-023 DIV with b==0: result_lo = all ones, result_hi = a, div_by_zero=1, 1-cycle latency.
REQ-024 SHR and SHL SHALL be logical; if b >= WIDTH, result_lo=0.
REQ-025 ROR and ROL SHALL rotate by b mod WIDTH; b mod WIDTH == 0 returns a unchanged.
REQ-026 Illegal op: result_hi = result_lo = 0, illegal_op=1.
REQ-027 Result outputs and flags SHALL hold their values from the last done until the next done; flags SHALL be cleared when a new done is produced without the corresponding condition.
REQ-028 A start accepted in DONE SHALL begin the next operation with no idle cycle (back-to-back).

Reset
REQ-029 reset low at a clk edge SHALL force IDLE and set busy, done, result_hi, result_lo, div_by_zero and illegal_op to 0.
REQ-030 reset asserted during RUN SHALL abort the operation with no done pulse; start SHALL be ignored while reset is low.

Structure
REQ-031 The shared package seq_alu_pkg SHALL hold the op-code constants and the FSM state encoding.
REQ-032 Iterative MUL/DIV SHALL live in sub-module seq_alu_muldiv (operand/accumulator registers, iteration counter, load/step controls); seq_alu holds the FSM, single-cycle ops and output registers.

Verification (WIDTH=32)
REQ-033 ADD a=FFFFFFFF, b=2 -> done 1 cycle later, result_lo=00000001, result_hi=0.
REQ-034 MUL a=FFFFFFFF, b=FFFFFFFF -> done 33 cycles after start, busy high 32 cycles; hi=FFFFFFFE, lo=00000001.
REQ-035 DIV a=100, b=7 -> lo=14, hi=2 after 33 cycles; then DIV a=5, b=0 -> done 1 cycle later, lo=FFFFFFFF, hi=5, div_by_zero=1.
REQ-036 ROL a=80000001, b=33 -> lo=00000003; SHR a=FFFFFFFF, b=32 -> lo=0; op=14 -> illegal_op=1, results 0.
REQ-037 MUL start, then a second start at cycle 5 and reset low at cycle 10 -> no done pulse, all outputs 0; the next ADD completes normally.
REQ-038 Back-to-back: start held through DONE with a new ADD -> two consecutive done pulses, each carrying its own correct result.
